// File: rtl/sys_pkg.sv
// Shared register-map constants for the system controller register file.
// Holds location addresses, reset values and REG2 bit-field positions.
package sys_pkg;

    // Register-map locations exported as REG0..REG3.
    localparam int ADDR_ALU_A     = 0;
    localparam int ADDR_ALU_B     = 1;
    localparam int ADDR_UART_CFG  = 2;
    localparam int ADDR_DIV_RATIO = 3;

    // Reset values: parity enabled, even parity, prescale 32; divide by 32.
    localparam logic [7:0] UART_CFG_RST  = 8'h81;
    localparam logic [7:0] DIV_RATIO_RST = 8'd32;

    // REG2 (UART config) field positions.
    localparam int PAR_EN_BIT   = 0;
    localparam int PAR_TYP_BIT  = 1;
    localparam int PRESCALE_LSB = 2;
    localparam int PRESCALE_MSB = 7;

    // Reset value of a storage location by index.
    function automatic logic [7:0] reset_value(int idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx == ADDR_UART_CFG) begin
            v = UART_CFG_RST;
        end else if (idx == ADDR_DIV_RATIO) begin
            v = DIV_RATIO_RST;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Controller-addressed register file with registered read data/valid.
// Ports: CLK, RST_n (async low), WrEn, RdEn, Address, WrData -> RdData,
// RdData_Valid, REG0..REG3 (locations 0..3 wired straight from storage).
module reg_file
    import sys_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             WrEn,
    input  logic             RdEn,
    input  logic [7:0]       Address,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] RdData,
    output logic             RdData_Valid,
    output logic [WIDTH-1:0] REG0,
    output logic [WIDTH-1:0] REG1,
    output logic [WIDTH-1:0] REG2,
    output logic [WIDTH-1:0] REG3
);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [WIDTH-1:0]      rd_data_q;
    logic [WIDTH-1:0]      rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;

    // Any set bit above the decoded field makes the access out of range.
    assign in_range = ((Address >> ADDR_WIDTH) == 8'd0);
    assign idx      = Address[ADDR_WIDTH-1:0];

    // Write wins over read; an out-of-range read still answers (with 0)
    // so the controller never waits on a valid that does not come.
    always_comb begin
        mem_d      = mem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (WrEn) begin
            if (in_range) begin
                mem_d[idx] = WrData;
            end
        end else if (RdEn) begin
            rd_valid_d = 1'b1;
            rd_data_d  = in_range ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(reset_value(i));
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RdData       = rd_data_q;
    assign RdData_Valid = rd_valid_q;
    assign REG0         = mem_q[ADDR_ALU_A];
    assign REG1         = mem_q[ADDR_ALU_B];
    assign REG2         = mem_q[ADDR_UART_CFG];
    assign REG3         = mem_q[ADDR_DIV_RATIO];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, async reset
// sequences and randomized traffic against a behavioural model.
module tb_reg_file;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       WrEn = 1'b0;
    logic       RdEn = 1'b0;
    logic [7:0] Address = 8'h00;
    logic [7:0] WrData = 8'h00;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] REG0, REG1, REG2, REG3;

    reg_file dut (
        .CLK(CLK), .RST_n(RST_n), .WrEn(WrEn), .RdEn(RdEn),
        .Address(Address), .WrData(WrData), .RdData(RdData),
        .RdData_Valid(RdData_Valid), .REG0(REG0), .REG1(REG1),
        .REG2(REG2), .REG3(REG3)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl_mem [16];
    logic [7:0] mdl_rd;
    logic       mdl_vld;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_vld;
        logic [7:0] r0, r1, r2, r3;
    } vec_t;

    vec_t vec [13];

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        mdl_mem[2] = 8'h81;
        mdl_mem[3] = 8'd32;
        mdl_rd  = 8'h00;
        mdl_vld = 1'b0;
    endtask

    task automatic model_step(logic wr, logic rd, logic [7:0] a, logic [7:0] d);
        if (wr) begin
            if (a < 8'd16) mdl_mem[a[3:0]] = d;
            mdl_vld = 1'b0;
        end else if (rd) begin
            mdl_vld = 1'b1;
            mdl_rd  = (a < 8'd16) ? mdl_mem[a[3:0]] : 8'h00;
        end else begin
            mdl_vld = 1'b0;
        end
    endtask

    task automatic cycle(logic wr, logic rd, logic [7:0] a, logic [7:0] d);
        @(negedge CLK);
        WrEn = wr; RdEn = rd; Address = a; WrData = d;
        model_step(wr, rd, a, d);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, "_rd"}, RdData, mdl_rd);
        chk({tag, "_vld"}, {7'b0, RdData_Valid}, {7'b0, mdl_vld});
        chk({tag, "_r0"}, REG0, mdl_mem[0]);
        chk({tag, "_r1"}, REG1, mdl_mem[1]);
        chk({tag, "_r2"}, REG2, mdl_mem[2]);
        chk({tag, "_r3"}, REG3, mdl_mem[3]);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_r0"}, REG0, 8'h00);
        chk({tag, "_r1"}, REG1, 8'h00);
        chk({tag, "_r2"}, REG2, 8'h81);
        chk({tag, "_r3"}, REG3, 8'h20);
        chk({tag, "_rd"}, RdData, 8'h00);
        chk({tag, "_vld"}, {7'b0, RdData_Valid}, 8'h00);
    endtask

    initial begin
        //        wr rd addr   wdata  rd     v  r0     r1     r2     r3
        vec[0]  = '{1, 0, 8'h05, 8'h5A, 8'h00, 0, 8'h00, 8'h00, 8'h81, 8'h20};
        vec[1]  = '{0, 1, 8'h05, 8'h00, 8'h5A, 1, 8'h00, 8'h00, 8'h81, 8'h20};
        vec[2]  = '{1, 0, 8'h00, 8'h0C, 8'h5A, 0, 8'h0C, 8'h00, 8'h81, 8'h20};
        vec[3]  = '{1, 0, 8'h01, 8'h03, 8'h5A, 0, 8'h0C, 8'h03, 8'h81, 8'h20};
        vec[4]  = '{1, 1, 8'h02, 8'h02, 8'h5A, 0, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[5]  = '{1, 0, 8'h14, 8'hFF, 8'h5A, 0, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[6]  = '{0, 1, 8'h14, 8'h00, 8'h00, 1, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[7]  = '{0, 1, 8'h00, 8'h00, 8'h0C, 1, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[8]  = '{0, 1, 8'h01, 8'h00, 8'h03, 1, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[9]  = '{0, 1, 8'h03, 8'h00, 8'h20, 1, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[10] = '{0, 0, 8'h03, 8'h00, 8'h20, 0, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[11] = '{0, 1, 8'h04, 8'h00, 8'h00, 1, 8'h0C, 8'h03, 8'h02, 8'h20};
        vec[12] = '{0, 0, 8'h04, 8'h00, 8'h00, 0, 8'h0C, 8'h03, 8'h02, 8'h20};

        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge CLK);
        RST_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wdata);
            chk($sformatf("v%0d_rd", i), RdData, vec[i].exp_rd);
            chk($sformatf("v%0d_vld", i), {7'b0, RdData_Valid},
                {7'b0, vec[i].exp_vld});
            chk($sformatf("v%0d_r0", i), REG0, vec[i].r0);
            chk($sformatf("v%0d_r1", i), REG1, vec[i].r1);
            chk($sformatf("v%0d_r2", i), REG2, vec[i].r2);
            chk($sformatf("v%0d_r3", i), REG3, vec[i].r3);
        end

        // Mid-cycle asynchronous reset while a read is valid.
        cycle(1'b0, 1'b1, 8'h00, 8'h00);
        chk("pre_rst_vld", {7'b0, RdData_Valid}, 8'h01);
        #2;
        RST_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();

        // Write presented while reset still low at the edge is discarded.
        @(negedge CLK);
        WrEn = 1'b1; RdEn = 1'b0; Address = 8'h00; WrData = 8'h77;
        @(posedge CLK);
        #1;
        check_reset_vals("held");

        // First edge after release operates normally.
        @(negedge CLK);
        RST_n = 1'b1;
        model_step(1'b1, 1'b0, 8'h00, 8'h77);
        @(posedge CLK);
        #1;
        chk("rel_r0", REG0, 8'h77);
        check_model("rel");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       wr, rd;
            logic [7:0] a, d;
            wr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(16, 255));
            else a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            cycle(wr, rd, a, d);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Register file addressed by the system controller in the REF_CLK domain. It stores ALU operands, UART configuration and the TX clock divide ratio, and serves controller read requests with a registered read-data/valid pair. Locations 0–3 are permanently exported as REG0–REG3 to the ALU, UART_RX and the TX clock divider.

## Interface
Parameters:
- WIDTH, 8: data width of each location.
- DEPTH, 16: number of locations.
- ADDR_WIDTH, 4: decoded address bits; must satisfy 2**ADDR_WIDTH == DEPTH.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK, input, 1: REF_CLK domain clock; all state updates on the rising edge.
- RST_n, input, 1: asynchronous, active-low reset.
- WrEn, input, 1: write strobe; level-sampled each cycle.
- RdEn, input, 1: read strobe; level-sampled each cycle.
- Address, input, 8: location index from the controller; only bits [ADDR_WIDTH-1:0] are decoded.
- WrData, input, WIDTH: write data.
- RdData, output, WIDTH: registered read data.
- RdData_Valid, output, 1: high for exactly the cycles following a sampled read.
- REG0, output, WIDTH: ALU operand A (location 0).
- REG1, output, WIDTH: ALU operand B (location 1).
- REG2, output, WIDTH: UART config (location 2): bit0 PAR_EN, bit1 PAR_TYP, bits[7:2] prescale.
- REG3, output, WIDTH: TX clock divide ratio (location 3).

## Operation
- Reset values:
  - All locations 0, except REG2 = 8'b1000_0001 (parity enabled, even parity, prescale 32) and REG3 = 8'd32.
  - RdData = 0, RdData_Valid = 0.
- Address range:
  - Address[7:ADDR_WIDTH] != 0 is out of range.
  - An out-of-range write is dropped with no state change.
  - An out-of-range read returns RdData = 0 with RdData_Valid = 1, so the controller never stalls.
- Write: when WrEn=1 and RdEn=0, mem[Address] <= WrData at the edge.
- Read: when RdEn=1 and WrEn=0, RdData <= mem[Address] and RdData_Valid <= 1 at the edge.
- Read held high: RdEn is a level. Holding it high gives RdData_Valid=1 on every following cycle, and RdData tracks Address.
- Simultaneous WrEn and RdEn: the write is performed, the read is ignored, and RdData_Valid <= 0. Write has priority.
- Idle cycle (neither strobe): RdData holds its last value; RdData_Valid <= 0.
- Read-after-write to the same location on the next cycle returns the new data. There is no bypass within the same cycle, since simultaneous access is already resolved above.
- REG0–REG3 are wired directly from storage. They reflect a write on the cycle after the write edge.

## Timing
- Write latency: 1 cycle (storage and REGn update at the edge where WrEn is sampled).
- Read latency: 1 cycle. RdData and RdData_Valid are both registered and change together.
- No combinational path from any input to any output.
- Reset asserted mid-operation: all state returns asynchronously to the reset values, and RdData_Valid drops immediately. A write in flight on the reset-release edge is discarded only if RST_n is still low at that edge.
- First edge after RST_n deasserts: normal operation.

## Structure
- Shared package (sys_pkg) holds:
  - Address constants: ADDR_ALU_A=0, ADDR_ALU_B=1, ADDR_UART_CFG=2, ADDR_DIV_RATIO=3.
  - Reset constants: UART_CFG_RST=8'h81, DIV_RATIO_RST=8'd32.
  - Bit-field positions of the REG2 fields.
- No sub-module: one flat module with a storage array, a decode/priority block and registered read outputs.

## Test plan
- Reset: assert RST_n=0 mid-simulation → REG0=0, REG1=0, REG2=8'h81, REG3=8'h20, RdData=0, RdData_Valid=0, asynchronously.
- Write/read: write 8'h5A to Address 5, then RdEn at Address 5 the next cycle → RdData=8'h5A with RdData_Valid=1 exactly one cycle after RdEn.
- Operand export: write 8'h0C to Address 0 and 8'h03 to Address 1 → REG0=8'h0C and REG1=8'h03 the cycle after each write.
- Simultaneous strobes: WrEn=RdEn=1, Address 2, WrData=8'h02 → REG2=8'h02 next cycle, RdData_Valid=0, RdData unchanged.
- Out of range: write 8'hFF to Address 8'h14 → no location changes. A read at Address 8'h14 → RdData=0 with RdData_Valid=1.
- Held read: RdEn high for 3 cycles while Address steps 0→1→3 → three consecutive valid cycles returning REG0, REG1, REG3 in order; RdData_Valid drops the cycle after RdEn falls.
